if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the RV64 pipeline. Owns the architectural PC and fetches 32-bit
//  instructions over a valid/ready memory handshake. It presents each fetched instruction to the
//  IF/ID register. It consumes the MEM-stage branch decision (pc_src1 + target) as a redirect
//  and raises the flushes for the three younger in-flight stages.
// PARAMETERS
//  RESET_PC   64'h0   PC loaded on reset
//  XLEN       64      address width (only 64 is supported)
// PORTS
//  clk                 in   1     clock, all state updates on rising edge
//  rst                 in   1     synchronous reset, active-high
//  stall_i             in   1     hazard unit: IF/ID not accepting; hold presented instruction
//  redirect_i          in   1     pc_src1 from MEM-stage branch resolution (taken)
//  redirect_target_i   in   XLEN  branch/jump target from MEM stage
//  imem_req_valid_o    out  1     fetch request valid
//  imem_req_ready_i    in   1     memory accepts request
//  imem_addr_o         out  XLEN  fetch address (= pc)
//  imem_resp_valid_i   in   1     instruction returned (1-cycle pulse)
//  imem_resp_data_i    in   32    returned instruction
//  if_valid_o          out  1     output slot holds an instruction
//  if_pc_o             out  XLEN  PC of presented instruction
//  if_inst_o           out  32    presented instruction
//  flush_ifid_o        out  1     squash IF/ID
//  flush_idex_o        out  1     squash ID/EX
//  flush_exmem_o       out  1     squash EX/MEM
//  misalign_o          out  1     registered pulse: redirect target had [1:0]!=0
// BEHAVIOUR
//  - Reset (rst high at edge): pc=RESET_PC, state=REQ, drop=0, if_valid_o=0, if_pc_o=0,
//    if_inst_o=0, misalign_o=0. During the reset cycle imem_req_valid_o=0 and all flushes=0.
//  - FSM states: REQ, WAIT, HOLD. At most one outstanding request; drop flag marks it stale.
//  - REQ: imem_req_valid_o=1, imem_addr_o=pc. On imem_req_ready_i, go to WAIT.
//  - WAIT: imem_req_valid_o=0. On imem_resp_valid_i with drop=1: discard, drop<=0, go to REQ.
//    On imem_resp_valid_i with drop=0: load slot (if_valid_o<=1, if_pc_o<=pc,
//    if_inst_o<=data); pc<=pc+4 (wraps mod 2^64). Next state is HOLD if stall_i, else REQ.
//  - Slot consumption: the slot is consumed on any cycle with if_valid_o=1 and stall_i=0.
//    A consumed slot that is not reloaded in the same cycle clears if_valid_o.
//  - HOLD: slot full, no request issued. When stall_i=0 the slot is consumed; go to REQ.
//  - Steady-state throughput: 1 instruction per 2 cycles with a 1-cycle-latency memory.
//  - Redirect (redirect_i=1) has priority over stall, responses and handshakes in every state:
//    * flush_ifid_o/flush_idex_o/flush_exmem_o = redirect_i, combinational, same cycle.
//    * pc<=redirect_target_i with [1:0] forced to 0; misalign_o<=|target[1:0] (1-cycle pulse).
//    * if_valid_o<=0. A response arriving in the same cycle is discarded.
//    * Outstanding request: if WAIT without a response this cycle, or REQ with handshake this
//      cycle, set drop<=1 and go to WAIT. Otherwise clear drop and go to REQ.
//  - imem_addr_o is stable while imem_req_valid_o=1 and not accepted, except on a redirect.
//    After a redirect the address changes to the new target in the next cycle.
//  - Back-to-back redirects: the last one wins; drop stays set while a request is outstanding.
//  - rst during WAIT: the in-flight response is ignored because the state returns to REQ.
//    Memory must tolerate the orphan response.
//  - Outputs if_* are registered. flush_* and imem_req_valid_o are decoded from state/inputs.
// STRUCTURE
//  - Shared package: fetch-state enum (REQ/WAIT/HOLD), INST_W=32, PC_STEP=4, RESET_PC default.
//  - Keep this a single module. The optional sub-module if_out_slot holds the if_* register and
//    the consume/load logic.
// TESTING
//  1. rst 2 cycles, memory ready=1 with 1-cycle latency returning 32'h00000013 -> first request
//     addr 0x0; if_pc_o 0x0, 0x4, 0x8 on successive deliveries, if_valid_o every 2 cycles.
//  2. Hold stall_i=1 for 5 cycles after a delivery -> if_pc_o/if_inst_o held, no
//     imem_req_valid_o. After release, the next request addr is the previous pc+4.
//  3. redirect_i=1, target 0x1000 while in WAIT -> flushes pulse same cycle; the stale response
//     is discarded; next request addr 0x1000; next if_pc_o 0x1000.
//  4. redirect_i coincident with stall_i=1 and a full slot -> if_valid_o=0 next cycle and a
//     fetch from the target. Redirect wins.
//  5. Target 0x1002 -> misalign_o pulses one cycle; fetch addr 0x1000.
//  6. pc=64'hFFFF_FFFF_FFFF_FFFC delivered -> next fetch addr 0x0 (wrap). imem_req_ready_i
//     held low 4 cycles -> imem_addr_o stable and req valid held.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the RV64 instruction-fetch stage: the fetch FSM
// state encoding, instruction width, PC step and default reset PC, plus
// small helpers for redirect-target alignment.
// ----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    // Fetch FSM: REQ issues a request, WAIT has one request outstanding,
    // HOLD keeps a delivered instruction while the decode stage is stalled.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam int          INST_W       = 32;
    localparam logic [63:0] PC_STEP      = 64'd4;
    localparam logic [63:0] DEF_RESET_PC = 64'h0;

    // Instructions are word aligned: the low two address bits are dropped.
    function automatic logic [63:0] align_pc(input logic [63:0] target);
        return {target[63:2], 2'b00};
    endfunction

    // A redirect target is misaligned when either low address bit is set.
    function automatic logic is_misaligned(input logic [63:0] target);
        return |target[1:0];
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage of the RV64 pipeline. Owns the architectural PC,
// fetches one 32-bit instruction at a time over a valid/ready memory
// handshake and presents it to the IF/ID register. A MEM-stage redirect
// reloads the PC, squashes the presented instruction, marks any in-flight
// request stale and raises the flushes for the younger stages.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   stall_i               IF/ID not accepting: hold the presented instruction
//   redirect_i            taken branch/jump from MEM stage
//   redirect_target_i     redirect target address
//   imem_req_valid_o      fetch request valid (decoded from state)
//   imem_req_ready_i      memory accepts the request
//   imem_addr_o           fetch address (the PC)
//   imem_resp_valid_i     instruction returned (single-cycle pulse)
//   imem_resp_data_i      returned instruction
//   if_valid_o            output slot holds an instruction (registered)
//   if_pc_o, if_inst_o    PC and instruction of the slot (registered)
//   flush_ifid_o/idex_o/exmem_o  squash the younger stages (combinational)
//   misalign_o            registered pulse: redirect target low bits nonzero
// ----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEF_RESET_PC,
    parameter int          XLEN     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_target_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [XLEN-1:0]   imem_addr_o,
    input  logic              imem_resp_valid_i,
    input  logic [INST_W-1:0] imem_resp_data_i,
    output logic              if_valid_o,
    output logic [XLEN-1:0]   if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              flush_exmem_o,
    output logic              misalign_o
);

    fetch_state_e      r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_drop;
    logic              r_if_valid;
    logic [XLEN-1:0]   r_if_pc;
    logic [INST_W-1:0] r_if_inst;
    logic              r_misalign;

    logic              w_req_valid;
    logic              w_flush;
    logic              w_keep_outstanding;

    // Request and flush decode; both are forced low while reset is held.
    always_comb begin
        w_req_valid = 1'b0;
        w_flush     = 1'b0;
        if (rst) begin
            w_req_valid = 1'b0;
            w_flush     = 1'b0;
        end else begin
            w_req_valid = (r_state == ST_REQ);
            w_flush     = redirect_i;
        end
    end

    // On a redirect, a request is still in flight when we are waiting without
    // a response this cycle, or a request is being accepted this cycle.
    always_comb begin
        w_keep_outstanding = 1'b0;
        if (r_state == ST_WAIT) begin
            w_keep_outstanding = !imem_resp_valid_i;
        end else if (r_state == ST_REQ) begin
            w_keep_outstanding = imem_req_ready_i;
        end else begin
            w_keep_outstanding = 1'b0;
        end
    end

    // Fetch FSM, PC, stale-request flag and the presented-instruction slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_REQ;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_inst  <= '0;
            r_misalign <= 1'b0;
        end else if (redirect_i) begin
            // Redirect beats stall, responses and handshakes in every state.
            r_pc       <= align_pc(redirect_target_i);
            r_misalign <= is_misaligned(redirect_target_i);
            r_if_valid <= 1'b0;
            if (w_keep_outstanding) begin
                r_drop  <= 1'b1;
                r_state <= ST_WAIT;
            end else begin
                r_drop  <= 1'b0;
                r_state <= ST_REQ;
            end
        end else begin
            r_misalign <= 1'b0;
            // Consumption first; a load in the same cycle overrides it below.
            if (r_if_valid && !stall_i) begin
                r_if_valid <= 1'b0;
            end else begin
                r_if_valid <= r_if_valid;
            end
            case (r_state)
                ST_REQ: begin
                    if (imem_req_ready_i) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid_i && r_drop) begin
                        r_drop  <= 1'b0;
                        r_state <= ST_REQ;
                    end else if (imem_resp_valid_i) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_pc;
                        r_if_inst  <= imem_resp_data_i;
                        r_pc       <= r_pc + PC_STEP;
                        r_state    <= stall_i ? ST_HOLD : ST_REQ;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        r_state <= ST_REQ;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_state <= ST_REQ;
                end
            endcase
        end
    end

    assign imem_req_valid_o = w_req_valid;
    assign imem_addr_o      = r_pc;
    assign flush_ifid_o     = w_flush;
    assign flush_idex_o     = w_flush;
    assign flush_exmem_o    = w_flush;
    assign if_valid_o       = r_if_valid;
    assign if_pc_o          = r_if_pc;
    assign if_inst_o        = r_if_inst;
    assign misalign_o       = r_misalign;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit: a behavioural fetch model plus a
// simple latency-programmable instruction memory, driven first by directed
// scenarios with literal expectations and then by randomized traffic.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [63:0] redirect_target_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_addr_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        if_valid_o;
    logic [63:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        flush_ifid_o;
    logic        flush_idex_o;
    logic        flush_exmem_o;
    logic        misalign_o;

    if_fetch_unit #(.RESET_PC(64'h0), .XLEN(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_addr_o       (imem_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .if_valid_o        (if_valid_o),
        .if_pc_o           (if_pc_o),
        .if_inst_o         (if_inst_o),
        .flush_ifid_o      (flush_ifid_o),
        .flush_idex_o      (flush_idex_o),
        .flush_exmem_o     (flush_exmem_o),
        .misalign_o        (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural view of the fetch stage: is a request outstanding, is it
    // stale, is a delivered instruction parked waiting for decode.
    bit          m_known;
    bit          m_outstanding;
    bit          m_stale;
    bit          m_parked;
    logic [63:0] m_pc;
    bit          m_slot_v;
    logic [63:0] m_slot_pc;
    logic [31:0] m_slot_inst;
    bit          m_mis;

    // Memory model: one response `lat` cycles after acceptance.
    int          mem_cnt = 0;
    int          lat = 1;
    logic [31:0] mem_data;
    bit          fixed_data = 1'b1;

    // Values sampled during the last step, for literal checks.
    logic        smp_req;
    logic [2:0]  smp_flush;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    // Advance the model by one clock edge from the inputs of this cycle.
    task automatic model_edge(input bit rs, input bit st, input bit rd,
                              input logic [63:0] tg, input bit rdy,
                              input bit rv, input logic [31:0] rdat);
        bit req_now;
        req_now = !m_outstanding && !m_parked;
        if (rs) begin
            m_known = 1'b1; m_outstanding = 1'b0; m_stale = 1'b0; m_parked = 1'b0;
            m_pc = 64'h0; m_slot_v = 1'b0; m_slot_pc = 64'h0; m_slot_inst = 32'h0; m_mis = 1'b0;
        end else if (rd) begin
            m_mis = (tg % 4) != 0;
            m_pc = tg - (tg % 4);
            m_slot_v = 1'b0;
            m_parked = 1'b0;
            if ((m_outstanding && !rv) || (req_now && rdy)) begin
                m_outstanding = 1'b1; m_stale = 1'b1;
            end else begin
                m_outstanding = 1'b0; m_stale = 1'b0;
            end
        end else begin
            m_mis = 1'b0;
            if (m_slot_v && !st) m_slot_v = 1'b0;
            if (m_parked) begin
                if (!st) m_parked = 1'b0;
            end else if (!m_outstanding) begin
                if (rdy) m_outstanding = 1'b1;
            end else if (rv) begin
                m_outstanding = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    m_slot_v = 1'b1; m_slot_pc = m_pc; m_slot_inst = rdat;
                    m_pc = m_pc + 64'd4;
                    m_parked = st;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, advance model and memory.
    task automatic step(input bit rs, input bit st, input bit rd,
                        input logic [63:0] tg, input bit rdy);
        bit exp_req;
        bit acc;
        @(negedge clk);
        rst = rs; stall_i = st; redirect_i = rd; redirect_target_i = tg;
        imem_req_ready_i = rdy;
        imem_resp_valid_i = (mem_cnt == 1);
        imem_resp_data_i  = (mem_cnt == 1) ? mem_data : 32'h0;
        #1;
        smp_req   = imem_req_valid_o;
        smp_flush = {flush_ifid_o, flush_idex_o, flush_exmem_o};
        if (m_known) begin
            exp_req = !rs && !m_outstanding && !m_parked;
            chk("req_valid", {63'h0, imem_req_valid_o}, {63'h0, exp_req});
            if (exp_req) chk("addr", imem_addr_o, m_pc);
            chk("flush", {61'h0, smp_flush}, {61'h0, {3{rd && !rs}}});
            chk("if_valid", {63'h0, if_valid_o}, {63'h0, m_slot_v});
            chk("if_pc", if_pc_o, m_slot_pc);
            chk("if_inst", {32'h0, if_inst_o}, {32'h0, m_slot_inst});
            chk("misalign", {63'h0, misalign_o}, {63'h0, m_mis});
        end
        acc = imem_req_valid_o && rdy;
        model_edge(rs, st, rd, tg, rdy, imem_resp_valid_i, imem_resp_data_i);
        if (mem_cnt > 0) mem_cnt--;
        if (acc) begin
            mem_cnt  = lat;
            mem_data = fixed_data ? 32'h0000_0013 : mem_word(imem_addr_o);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          r_rs, r_st, r_rd, r_rdy;
        logic [63:0] r_tg;
        int          sel;
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_target_i = 64'h0;
        imem_req_ready_i = 1'b0; imem_resp_valid_i = 1'b0; imem_resp_data_i = 32'h0;
        m_known = 1'b0;

        // Reset and sequential fetch with a 1-cycle memory.
        step(1, 0, 0, 64'h0, 0);
        step(1, 0, 0, 64'h0, 0);
        chk("rst_if_valid", {63'h0, if_valid_o}, 64'h0);
        chk("rst_addr", imem_addr_o, 64'h0);
        step(0, 0, 0, 64'h0, 1);
        chk("wait_no_req", {63'h0, imem_req_valid_o}, 64'h0);
        step(0, 0, 0, 64'h0, 1);
        chk("d0_valid", {63'h0, if_valid_o}, 64'h1);
        chk("d0_pc", if_pc_o, 64'h0);
        chk("d0_inst", {32'h0, if_inst_o}, 64'h13);
        step(0, 0, 0, 64'h0, 1);
        chk("d0_consumed", {63'h0, if_valid_o}, 64'h0);
        step(0, 0, 0, 64'h0, 1);
        chk("d1_pc", if_pc_o, 64'h4);
        step(0, 0, 0, 64'h0, 1);
        step(0, 1, 0, 64'h0, 1);
        chk("d2_pc", if_pc_o, 64'h8);

        // Stall holds the slot and suppresses requests.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 64'h0, 1);
            chk("hold_pc", if_pc_o, 64'h8);
            chk("hold_valid", {63'h0, if_valid_o}, 64'h1);
            chk("hold_noreq", {63'h0, imem_req_valid_o}, 64'h0);
        end
        step(0, 0, 0, 64'h0, 1);
        chk("rel_req", {63'h0, imem_req_valid_o}, 64'h1);
        chk("rel_addr", imem_addr_o, 64'hC);

        // Redirect while waiting: stale response discarded.
        lat = 2;
        step(0, 0, 0, 64'h0, 1);
        step(0, 0, 1, 64'h1000, 1);
        chk("redir_flush", {61'h0, smp_flush}, 64'h7);
        lat = 1;
        step(0, 0, 0, 64'h0, 1);
        chk("stale_dropped", {63'h0, if_valid_o}, 64'h0);
        chk("redir_addr", imem_addr_o, 64'h1000);
        step(0, 0, 0, 64'h0, 1);
        step(0, 1, 0, 64'h0, 1);
        chk("redir_pc", if_pc_o, 64'h1000);

        // Redirect coincident with stall and a full slot.
        step(0, 1, 1, 64'h2000, 1);
        chk("stall_redir_valid", {63'h0, if_valid_o}, 64'h0);
        chk("stall_redir_req", {63'h0, imem_req_valid_o}, 64'h1);
        chk("stall_redir_addr", imem_addr_o, 64'h2000);

        // Misaligned target, accepted handshake in the same cycle.
        step(0, 0, 1, 64'h1002, 1);
        chk("mis_pulse", {63'h0, misalign_o}, 64'h1);
        chk("mis_addr", imem_addr_o, 64'h1000);
        step(0, 0, 0, 64'h0, 0);
        chk("mis_clear", {63'h0, misalign_o}, 64'h0);
        chk("mis_refetch", imem_addr_o, 64'h1000);

        // PC wrap, then memory not ready for 4 cycles.
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        step(0, 0, 0, 64'h0, 1);
        step(0, 0, 0, 64'h0, 0);
        chk("wrap_pc", if_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", imem_addr_o, 64'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 64'h0, 0);
            chk("nrdy_req", {63'h0, imem_req_valid_o}, 64'h1);
            chk("nrdy_addr", imem_addr_o, 64'h0);
        end

        // Randomized traffic against the model.
        fixed_data = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            r_rs  = ($urandom_range(0, 99) == 0);
            r_st  = ($urandom_range(0, 99) < 30);
            r_rd  = ($urandom_range(0, 99) < 8);
            r_rdy = ($urandom_range(0, 99) < 60);
            sel   = $urandom_range(0, 7);
            if (sel == 0)      r_tg = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            else if (sel < 4)  r_tg = 64'($urandom_range(0, 4095));
            else               r_tg = {$urandom, $urandom};
            lat = $urandom_range(1, 3);
            step(r_rs, r_st, r_rd, r_tg, r_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
